// File: rtl/irq_arbiter.sv
// irq_arbiter: shares one CPU interrupt line among N_SRC level-sensitive sources
// using round-robin arbitration, with a 4-register window on the 8-bit processor bus.
module irq_arbiter #(
  parameter int         N_SRC       = 4,
  parameter logic [7:0] BASE_ADDR   = 8'hB0,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  input  logic [N_SRC-1:0] IRQ_RAISE,
  output logic [N_SRC-1:0] IRQ_ACK,
  output logic             CPU_INT_RAISE,
  input  logic             CPU_INT_ACK
);
  typedef enum logic [1:0] {IDLE, RAISE, WAIT_CLR} state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  state_t           state_reg;
  logic [N_SRC-1:0] mask_reg;
  logic [2:0]       id_reg;
  logic [2:0]       ptr_reg;
  logic             err_reg;
  logic [7:0]       count_reg;
  logic [3:0]       tmo_reg;
  logic             int_raise_reg;
  logic             ack_pulse_reg;
  logic             rd_en_reg;
  logic [7:0]       rd_data_reg;

  logic [7:0]       offset;
  logic             in_range;
  logic [1:0]       reg_sel;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] raw_sh;
  logic             src_active;
  logic             clr_done;
  logic [3:0]       pick;

  assign offset     = BUS_ADDR - BASE_ADDR;
  assign in_range   = (offset < 8'd4);
  assign reg_sel    = offset[1:0];
  assign pending    = IRQ_RAISE & mask_reg;
  assign raw_sh     = IRQ_RAISE >> id_reg;
  assign src_active = raw_sh[0];
  assign clr_done   = (state_reg == WAIT_CLR) && !src_active;

  // Returns {valid, id}: first pending source strictly after ptr, wrapping.
  function automatic logic [3:0] rr_pick(input logic [N_SRC-1:0] p, input logic [2:0] ptr);
    logic [3:0]       result;
    logic [N_SRC-1:0] sh;
    int               idx;
    result = 4'b0000;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      sh = p >> idx;
      if (sh[0]) result = {1'b1, 3'(idx)};
    end
    return result;
  endfunction

  assign pick = rr_pick(pending, ptr_reg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      int_raise_reg <= 1'b0;
      ack_pulse_reg <= 1'b0;
      id_reg        <= 3'd0;
      ptr_reg       <= 3'(N_SRC - 1);
      err_reg       <= 1'b0;
      tmo_reg       <= 4'd0;
    end else begin
      ack_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick[3]) begin
            id_reg        <= pick[2:0];
            int_raise_reg <= 1'b1;
            state_reg     <= RAISE;
          end
        end
        RAISE: begin
          if (CPU_INT_ACK) begin
            ack_pulse_reg <= 1'b1;
            int_raise_reg <= 1'b0;
            tmo_reg       <= 4'd0;
            state_reg     <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          if (!src_active) begin
            ptr_reg   <= id_reg;
            state_reg <= IDLE;
          end else if (tmo_reg == TIMEOUT_LAST) begin
            ptr_reg   <= id_reg;
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A COUNT write beats a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_reg  <= '1;
      count_reg <= 8'd0;
    end else begin
      if (BUS_WE && in_range && reg_sel == 2'd0) mask_reg <= BUS_DATA[N_SRC-1:0];
      if (BUS_WE && in_range && reg_sel == 2'd3) count_reg <= 8'd0;
      else if (clr_done) count_reg <= count_reg + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en_reg   <= 1'b0;
      rd_data_reg <= 8'd0;
    end else begin
      rd_en_reg <= !BUS_WE && in_range;
      case (reg_sel)
        2'd0:    rd_data_reg <= 8'(mask_reg);
        2'd1:    rd_data_reg <= {state_reg != IDLE, err_reg, 3'b000, id_reg};
        2'd2:    rd_data_reg <= 8'(pending);
        default: rd_data_reg <= count_reg;
      endcase
    end
  end

  // Gating with BUS_WE keeps the driver off during a write that follows a read.
  assign BUS_DATA      = (rd_en_reg && !BUS_WE) ? rd_data_reg : 8'hzz;
  assign CPU_INT_RAISE = int_raise_reg;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ack
    assign IRQ_ACK[gi] = ack_pulse_reg && (id_reg == 3'(gi));
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_irq_arbiter;
  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'hB0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_we = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic       tb_en = 1'b0;
  logic [3:0] irq = 4'b0000;
  logic [3:0] irq_ack;
  logic       cpu_int_raise;
  logic       cpu_ack = 1'b0;
  wire  [7:0] bus_data;

  assign bus_data = tb_en ? tb_data : 8'hzz;

  int         checks = 0;
  int         errors = 0;
  int         m_ptr;
  int         m_count;
  logic       m_err;
  logic [3:0] m_mask;

  irq_arbiter #(.N_SRC(N), .BASE_ADDR(BASE), .ACK_TIMEOUT(15)) dut (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .IRQ_RAISE(irq), .IRQ_ACK(irq_ack), .CPU_INT_RAISE(cpu_int_raise), .CPU_INT_ACK(cpu_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference round-robin choice: first requesting source after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [3:0] p);
    for (int k = 1; k <= N; k++) begin
      automatic int idx = (ptr + k) % N;
      if (p[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] id_word(input logic valid, input logic err, input int id);
    return {valid, err, 3'b000, id[2:0]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_we = 1'b0; bus_addr = a; tb_en = 1'b0;
    @(negedge clk);
    d = bus_data;
    bus_addr = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; tb_data = d; tb_en = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; tb_en = 1'b0; bus_addr = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = 4'b0000; cpu_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    m_ptr = N - 1; m_count = 0; m_err = 1'b0; m_mask = 4'hF;
  endtask

  task automatic cpu_ack_cycle(output logic [3:0] ack_seen, output logic raise_seen);
    cpu_ack = 1'b1;
    step();
    ack_seen = irq_ack; raise_seen = cpu_int_raise;
    cpu_ack = 1'b0;
  endtask

  task automatic wait_raise(input string tag);
    int cyc = 0;
    while (cpu_int_raise !== 1'b1 && cyc < 40) begin step(); cyc++; end
    checks++;
    if (cpu_int_raise !== 1'b1) begin
      errors++; $display("FAIL %s wait_raise: CPU_INT_RAISE=%b required 1 within 40 cycles", tag, cpu_int_raise);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    checks++; if (irq_ack !== 4'b0000 || cpu_int_raise !== 1'b0) begin errors++; $display("FAIL reset_outputs: IRQ_ACK=%b CPU_INT_RAISE=%b required 0000/0", irq_ack, cpu_int_raise); end
    bus_read(BASE + 8'd0, d); checks++; if (d !== 8'h0F) begin errors++; $display("FAIL reset_mask: got %h required 0f", d); end
    bus_read(BASE + 8'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_id: got %h required 00", d); end
    bus_read(BASE + 8'd2, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h required 00", d); end
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_count: got %h required 00", d); end
    // Read MASK, then immediately write 00 to PENDING: the bus must carry only the bench's value.
    bus_we = 1'b0; bus_addr = BASE; tb_en = 1'b0;
    step();
    bus_we = 1'b1; bus_addr = BASE + 8'd2; tb_data = 8'h00; tb_en = 1'b1;
    #1;
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL driver_off_on_write: bus=%h required 00 (DUT driving)", bus_data); end
    step();
    bus_we = 1'b0; tb_en = 1'b0; bus_addr = 8'h00;
    bus_read(BASE + 8'd0, d); checks++; if (d !== 8'h0F) begin errors++; $display("FAIL pending_write_ignored: mask=%h required 0f", d); end
    $display("txn reset: register window read back");
  endtask

  task automatic test_single();
    logic [7:0] d; logic [3:0] a; logic r; int exp;
    do_reset();
    irq = 4'b0010;
    step();
    checks++; if (cpu_int_raise !== 1'b1) begin errors++; $display("FAIL single_latency: CPU_INT_RAISE=%b required 1", cpu_int_raise); end
    exp = rr_pick(m_ptr, irq & m_mask);
    bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b1, m_err, exp)) begin errors++; $display("FAIL single_id: got %h required %h", d, id_word(1'b1, m_err, exp)); end
    cpu_ack_cycle(a, r);
    checks++; if (a !== 4'b0010 || r !== 1'b0) begin errors++; $display("FAIL single_ack: IRQ_ACK=%b raise=%b required 0010/0", a, r); end
    irq = 4'b0000;
    step();
    checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_width: IRQ_ACK=%b required 0000", irq_ack); end
    m_ptr = exp; m_count++;
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'(m_count)) begin errors++; $display("FAIL single_count: got %h required %h", d, 8'(m_count)); end
    bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b0, m_err, exp)) begin errors++; $display("FAIL single_id_idle: got %h required %h", d, id_word(1'b0, m_err, exp)); end
    $display("txn single: id=%0d count=%0d", exp, m_count);
  endtask

  task automatic test_round_robin();
    logic [7:0] d; logic [3:0] a; logic [3:0] e_ack; logic r; int exp;
    do_reset();
    irq = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_raise("round_robin");
      exp = rr_pick(m_ptr, irq & m_mask);
      bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b1, m_err, exp)) begin errors++; $display("FAIL rr_id[%0d]: got %h required %h", i, d, id_word(1'b1, m_err, exp)); end
      cpu_ack_cycle(a, r);
      e_ack = 4'b0001 << exp;
      checks++; if (a !== e_ack) begin errors++; $display("FAIL rr_ack[%0d]: IRQ_ACK=%b required %b", i, a, e_ack); end
      irq = irq & ~e_ack;
      step();
      m_ptr = exp; m_count++;
      irq = (i == 3) ? 4'b0000 : 4'b0101;
      $display("txn rr %0d: serviced=%0d count=%0d", i, exp, m_count);
    end
    step();
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'(m_count)) begin errors++; $display("FAIL rr_count: got %h required %h", d, 8'(m_count)); end
  endtask

  task automatic test_masking();
    logic [7:0] d; logic [3:0] a; logic r; int exp;
    do_reset();
    bus_write(BASE, 8'h01); m_mask = 4'h1;
    irq = 4'b0100;
    repeat (3) step();
    checks++; if (cpu_int_raise !== 1'b0) begin errors++; $display("FAIL mask_blocks: CPU_INT_RAISE=%b required 0", cpu_int_raise); end
    bus_read(BASE + 8'd2, d); checks++; if (d !== {4'b0, irq & m_mask}) begin errors++; $display("FAIL mask_pending: got %h required %h", d, {4'b0, irq & m_mask}); end
    bus_write(BASE, 8'h04); m_mask = 4'h4;
    checks++; if (cpu_int_raise !== 1'b0) begin errors++; $display("FAIL mask_next_cycle: CPU_INT_RAISE=%b required 0", cpu_int_raise); end
    step();
    checks++; if (cpu_int_raise !== 1'b1) begin errors++; $display("FAIL mask_unblocks: CPU_INT_RAISE=%b required 1", cpu_int_raise); end
    exp = rr_pick(m_ptr, irq & m_mask);
    bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b1, m_err, exp)) begin errors++; $display("FAIL mask_id: got %h required %h", d, id_word(1'b1, m_err, exp)); end
    cpu_ack_cycle(a, r);
    checks++; if (a !== 4'b0100) begin errors++; $display("FAIL mask_ack: IRQ_ACK=%b required 0100", a); end
    irq = 4'b0000; step(); m_ptr = exp; m_count++;
    $display("txn mask: id=%0d", exp);
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic [3:0] a; logic r; int cyc; logic stray;
    do_reset();
    irq = 4'b1000;
    step();
    cpu_ack_cycle(a, r);
    checks++; if (a !== 4'b1000) begin errors++; $display("FAIL timeout_ack: IRQ_ACK=%b required 1000", a); end
    cyc = 0; stray = 1'b0;
    while (cpu_int_raise !== 1'b1 && cyc < 40) begin
      step(); cyc++;
      if (irq_ack !== 4'b0000) stray = 1'b1;
    end
    // 15 cycles in WAIT_CLR, one IDLE cycle, then re-raise.
    checks++; if (cyc != 16) begin errors++; $display("FAIL timeout_rearb: re-raise after %0d cycles required 16", cyc); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL timeout_stray_ack: extra IRQ_ACK seen=%b required 0", stray); end
    m_err = 1'b1; m_ptr = 3;
    bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b1, m_err, rr_pick(m_ptr, irq & m_mask))) begin errors++; $display("FAIL timeout_id: got %h required %h", d, id_word(1'b1, m_err, rr_pick(m_ptr, irq & m_mask))); end
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'(m_count)) begin errors++; $display("FAIL timeout_count: got %h required %h", d, 8'(m_count)); end
    cpu_ack_cycle(a, r);
    irq = 4'b0000; step(); m_count++;
    bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b0, m_err, 3)) begin errors++; $display("FAIL timeout_err_sticky: got %h required %h", d, id_word(1'b0, m_err, 3)); end
    $display("txn timeout: rearb_cycles=%0d count=%0d", cyc, m_count);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic [3:0] a; logic r;
    do_reset();
    irq = 4'b0001;
    step();
    rst = 1'b1; cpu_ack = 1'b1;
    step();
    checks++; if (irq_ack !== 4'b0000 || cpu_int_raise !== 1'b0) begin errors++; $display("FAIL reset_mid_raise: IRQ_ACK=%b raise=%b required 0000/0", irq_ack, cpu_int_raise); end
    rst = 1'b0; cpu_ack = 1'b0; irq = 4'b0000;
    step();
    checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL reset_mid_late_ack: IRQ_ACK=%b required 0000", irq_ack); end
    do_reset();
    irq = 4'b0001;
    step();
    cpu_ack_cycle(a, r);
    rst = 1'b1;
    step();
    rst = 1'b0; irq = 4'b0000;
    m_ptr = N - 1; m_count = 0; m_err = 1'b0;
    bus_read(BASE + 8'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_wait: id=%h required 00", d); end
    $display("txn reset_mid: done");
  endtask

  task automatic test_count_collision();
    logic [7:0] d; logic [3:0] a; logic r;
    do_reset();
    irq = 4'b0001;
    step();
    cpu_ack_cycle(a, r);
    irq = 4'b0000;
    bus_write(BASE + 8'd3, 8'h55);
    m_ptr = 0; m_count = 0;
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL count_write_wins: got %h required 00", d); end
    irq = 4'b0001;
    step();
    cpu_ack_cycle(a, r);
    irq = 4'b0000; step(); m_count++;
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'(m_count)) begin errors++; $display("FAIL count_after_clear: got %h required %h", d, 8'(m_count)); end
    $display("txn count_collision: count=%0d", m_count);
  endtask

  task automatic test_random();
    logic [7:0] d; logic [3:0] a; logic [3:0] e_ack; logic [3:0] rq; logic [3:0] mk; logic r; int exp; int dly; bit drop;
    do_reset();
    for (int t = 0; t < 24; t++) begin
      do begin
        rq = 4'($urandom_range(1, 15)); mk = 4'($urandom_range(1, 15));
      end while ((rq & mk) == 4'b0000);
      bus_write(BASE, {4'b0000, mk}); m_mask = mk;
      irq = rq;
      step();
      checks++; if (cpu_int_raise !== 1'b1) begin errors++; $display("FAIL rnd_raise[%0d]: CPU_INT_RAISE=%b required 1", t, cpu_int_raise); end
      exp = rr_pick(m_ptr, rq & m_mask);
      bus_read(BASE + 8'd1, d); checks++; if (d !== id_word(1'b1, m_err, exp)) begin errors++; $display("FAIL rnd_id[%0d]: got %h required %h", t, d, id_word(1'b1, m_err, exp)); end
      bus_read(BASE + 8'd2, d); checks++; if (d !== {4'b0000, rq & m_mask}) begin errors++; $display("FAIL rnd_pending[%0d]: got %h required %h", t, d, {4'b0000, rq & m_mask}); end
      drop = ($urandom_range(0, 2) == 0);
      if (drop) irq = 4'b0000;
      dly = $urandom_range(0, 2);
      repeat (dly) step();
      checks++; if (cpu_int_raise !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d]: CPU_INT_RAISE=%b required 1", t, cpu_int_raise); end
      cpu_ack_cycle(a, r);
      e_ack = 4'b0001 << exp;
      checks++; if (a !== e_ack || r !== 1'b0) begin errors++; $display("FAIL rnd_ack[%0d]: IRQ_ACK=%b raise=%b required %b/0", t, a, r, e_ack); end
      irq = 4'b0000;
      step();
      checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL rnd_ack_width[%0d]: IRQ_ACK=%b required 0000", t, irq_ack); end
      m_ptr = exp; m_count++;
      $display("txn rnd %0d: req=%b mask=%b drop=%0d id=%0d count=%0d", t, rq, mk, drop, exp, m_count);
    end
    bus_read(BASE + 8'd3, d); checks++; if (d !== 8'(m_count)) begin errors++; $display("FAIL rnd_count: got %h required %h", d, 8'(m_count)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_timeout();
    test_reset_mid();
    test_count_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Memory-mapped interrupt controller on the 8-bit processor bus.
- Shares the processor's single interrupt line between up to 8 peripheral sources: the mouse (MOUSE_INTERRUPT_RAISE/ACK pair), timer, and others.
- Round-robin arbitration, per-source mask, bus-readable source ID and service count.
- Routes the processor's acknowledge back to the serviced source as a one-cycle pulse.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 8'hB0, base bus address; registers occupy BASE_ADDR..BASE_ADDR+3.
- ACK_TIMEOUT, 15, max cycles in WAIT_CLR before forced return to IDLE (4-bit counter).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  processor write enable.
- IRQ_RAISE  in  N_SRC  level interrupt requests from peripherals.
- IRQ_ACK  out  N_SRC  one-cycle acknowledge pulse to the serviced source.
- CPU_INT_RAISE  out  1  interrupt request to processor.
- CPU_INT_ACK  in  1  processor acknowledge.

Behaviour:
- Reset applies in the cycle RESET is sampled high:
  - State=IDLE; CPU_INT_RAISE=0; IRQ_ACK=0.
  - MASK=all N_SRC bits 1; ID=0; ERR=0; COUNT=0.
  - Pointer=N_SRC-1, so source 0 wins first.
  - Bus driver off.
- Registers:
  - BASE+0 MASK, RW; bits >=N_SRC read 0.
  - BASE+1 ID, RO: bit7=VALID (state!=IDLE), bit6=ERR (sticky), bits[2:0]=latched id.
  - BASE+2 PENDING, RO: IRQ_RAISE & MASK.
  - BASE+3 COUNT, RW: any write clears it to 0.
- Bus writes: on posedge when BUS_WE=1 and BUS_ADDR matches; BUS_DATA captured.
- Bus reads:
  - Registered. When BUS_WE=0 and BUS_ADDR in range, output register loads at posedge and the driver enables.
  - Data appears on BUS_DATA the cycle after the address.
  - Driver disabled otherwise, including any cycle with BUS_WE=1.
  - Writes to ID/PENDING are ignored.
- Pending vector: P = IRQ_RAISE & MASK, sampled each cycle.
- FSM:
  - IDLE: if P!=0, select the first set bit searching from pointer+1 upward, wrapping modulo N_SRC. Latch id; next state RAISE. CPU_INT_RAISE goes high at the posedge that leaves IDLE, i.e. 1-cycle latency from P sampled nonzero.
  - RAISE: CPU_INT_RAISE=1. When CPU_INT_ACK sampled 1:
    - IRQ_ACK[id]=1 for exactly the next cycle.
    - CPU_INT_RAISE=0 from that cycle.
    - Go to WAIT_CLR; timeout counter cleared.
  - WAIT_CLR:
    - If IRQ_RAISE[id]==0 (raw, unmasked): go IDLE; pointer=id; COUNT++, wrapping 255->0.
    - Else, counter reaches ACK_TIMEOUT: go IDLE; pointer=id; ERR=1; COUNT unchanged.
- Boundary rules:
  - CPU_INT_ACK in IDLE or WAIT_CLR is ignored.
  - Mask bit cleared or source deasserting while in RAISE: the latched request is still serviced and IRQ_ACK still pulses (no retraction).
  - COUNT write in the same cycle as an increment: the write wins (COUNT=0).
  - MASK write takes effect for arbitration from the next cycle.
  - RESET mid-RAISE or mid-WAIT_CLR: immediate IDLE, no IRQ_ACK pulse, CPU_INT_RAISE=0 next cycle.
  - At most one IRQ_ACK bit is high in any cycle.

Test Plan:
- Reset, then read BASE+0..3:
  - MASK returns 8'h0F (N_SRC=4); ID, PENDING, COUNT return 8'h00.
  - Each value appears one cycle after its address.
  - BUS_DATA is Z when BUS_WE=1.
- Single request:
  - Stimulus: IRQ_RAISE=4'b0010 held until IRQ_ACK.
  - CPU_INT_RAISE high 1 cycle later; ID reads 8'h81.
  - CPU_INT_ACK pulse gives IRQ_ACK=4'b0010 for 1 cycle.
  - Source drops; COUNT=1; ID reads 8'h01.
- Round-robin: sources 0 and 2 held continuously, each dropping for 1 cycle after its ack; service order is 0,2,0,2 and COUNT=4.
- Masking:
  - Write MASK=8'h01; assert IRQ_RAISE=4'b0100.
  - No CPU_INT_RAISE; PENDING reads 8'h00.
  - Write MASK=8'h04; CPU_INT_RAISE asserts with id 2.
- Timeout: source 3 never deasserts after ack. After 15 cycles in WAIT_CLR, ID bit6=1, COUNT unchanged, state IDLE, and source 3 re-arbitrated.
- Reset mid-RAISE: no IRQ_ACK pulse; CPU_INT_RAISE=0 next cycle. Separately, COUNT write coinciding with increment leaves COUNT=0.
